// File: rtl/ga_grade_scan.sv
// Multivector grade analyser: scans LANES components per cycle, reports dominant grade,
// nonzero-grade mask, peak magnitude and a grade-projected copy. Optional perf counters: GA_GRADE_SCAN_PERF_EN.

module ga_grade_scan_lane #(
  parameter int DIM     = 5,
  parameter int COMP_W  = 16,
  parameter int IDX_W   = 5,
  parameter int GRADE_W = 3
) (
  input  logic [IDX_W-1:0]   idx_i,
  input  logic [COMP_W-1:0]  comp_i,
  input  logic [DIM:0]       keep_i,
  output logic [GRADE_W-1:0] grade_o,
  output logic [COMP_W-1:0]  mag_o,
  output logic               nz_o,
  output logic [COMP_W-1:0]  proj_o
);
  function automatic int binom(input int n, input int k);
    int c;
    c = 1;
    for (int i = 0; i < k; i++) c = c * (n - i) / (i + 1);
    return c;
  endfunction

  function automatic int cum_binom(input int n, input int g);
    int s;
    s = 0;
    for (int j = 0; j <= g; j++) s += binom(n, j);
    return s;
  endfunction

  // Components are sorted by grade, so the grade is the number of boundaries passed.
  logic [DIM-1:0] ge;
  for (genvar g = 0; g < DIM; g++) begin : g_bnd
    localparam int Bound = cum_binom(DIM, g);
    assign ge[g] = int'(idx_i) >= Bound;
  end

  always_comb begin
    grade_o = '0;
    for (int g = 0; g < DIM; g++) grade_o = grade_o + GRADE_W'(ge[g]);
  end

  assign mag_o  = comp_i[COMP_W-1] ? -comp_i : comp_i;
  assign nz_o   = |comp_i;
  assign proj_o = keep_i[grade_o] ? comp_i : '0;
endmodule

module ga_grade_scan #(
  parameter  int DIM      = 5,
  parameter  int COMP_W   = 16,
  parameter  int LANES    = 4,
  localparam int NUM_COMP = 2**DIM,
  localparam int GRADE_W  = $clog2(DIM+1)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [NUM_COMP*COMP_W-1:0] in_mv_i,
  input  logic [DIM:0]               in_keep_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [NUM_COMP*COMP_W-1:0] out_mv_o,
  output logic [GRADE_W-1:0]         out_grade_o,
  output logic [DIM:0]               out_grade_mask_o,
  output logic [COMP_W-1:0]          out_max_mag_o
`ifdef GA_GRADE_SCAN_PERF_EN
  ,
  output logic [31:0]                perf_ops_o,
  output logic [31:0]                perf_busy_o
`endif
);
  localparam int NUM_BEATS = NUM_COMP / LANES;
  localparam int IDX_W     = $clog2(NUM_COMP);
  localparam int BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

  if (NUM_COMP % LANES != 0) begin : g_lanes_chk
    $error("ga_grade_scan: NUM_COMP must be a multiple of LANES");
  end

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;
  typedef logic [NUM_COMP-1:0][COMP_W-1:0] mv_t;

  state_e                   state_q;
  logic [BEAT_W-1:0]        beat_q;
  mv_t                      mv_q, mv_d;
  logic [DIM:0]             keep_q;
  logic [DIM:0][COMP_W-1:0] gmax_q, gmax_d;
  logic [DIM:0]             nz_q, nz_d;
  logic                     in_rdy_q, out_vld_q;
  logic [GRADE_W-1:0]       grade_q, dom_d;
  logic [DIM:0]             mask_q;
  logic [COMP_W-1:0]        max_q, max_d;

  logic [LANES-1:0][IDX_W-1:0]   lane_idx;
  logic [LANES-1:0][COMP_W-1:0]  lane_comp, lane_mag, lane_proj;
  logic [LANES-1:0][GRADE_W-1:0] lane_grade;
  logic [LANES-1:0]              lane_nz;

  // Packed element j holds component NUM_COMP-1-j, i.e. ~k for a power-of-two count.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_idx[l]  = IDX_W'(int'(beat_q) * LANES + l);
    assign lane_comp[l] = mv_q[~lane_idx[l]];
    ga_grade_scan_lane #(
      .DIM(DIM), .COMP_W(COMP_W), .IDX_W(IDX_W), .GRADE_W(GRADE_W)
    ) u_lane (
      .idx_i  (lane_idx[l]),
      .comp_i (lane_comp[l]),
      .keep_i (keep_q),
      .grade_o(lane_grade[l]),
      .mag_o  (lane_mag[l]),
      .nz_o   (lane_nz[l]),
      .proj_o (lane_proj[l])
    );
  end

  always_comb begin
    mv_d   = mv_q;
    gmax_d = gmax_q;
    nz_d   = nz_q;
    for (int l = 0; l < LANES; l++) begin
      mv_d[~lane_idx[l]]    = lane_proj[l];
      nz_d[lane_grade[l]] |= lane_nz[l];
      if (lane_mag[l] > gmax_d[lane_grade[l]]) gmax_d[lane_grade[l]] = lane_mag[l];
    end
    // Strict compare while walking upward keeps ties on the lowest grade.
    dom_d = '0;
    max_d = gmax_d[0];
    for (int g = 1; g <= DIM; g++) begin
      if (gmax_d[g] > max_d) begin
        max_d = gmax_d[g];
        dom_d = GRADE_W'(g);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      mv_q      <= '0;
      keep_q    <= '0;
      gmax_q    <= '0;
      nz_q      <= '0;
      in_rdy_q  <= 1'b1;
      out_vld_q <= 1'b0;
      grade_q   <= '0;
      mask_q    <= '0;
      max_q     <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid_i) begin
          mv_q     <= in_mv_i;
          keep_q   <= in_keep_i;
          gmax_q   <= '0;
          nz_q     <= '0;
          beat_q   <= '0;
          in_rdy_q <= 1'b0;
          state_q  <= SCAN;
        end
        SCAN: begin
          mv_q   <= mv_d;
          gmax_q <= gmax_d;
          nz_q   <= nz_d;
          beat_q <= beat_q + BEAT_W'(1);
          if (beat_q == BEAT_W'(NUM_BEATS-1)) begin
            grade_q   <= dom_d;
            mask_q    <= nz_d;
            max_q     <= max_d;
            out_vld_q <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: if (out_ready_i) begin
          out_vld_q <= 1'b0;
          in_rdy_q  <= 1'b1;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready_o       = in_rdy_q;
  assign out_valid_o      = out_vld_q;
  assign out_mv_o         = mv_q;
  assign out_grade_o      = grade_q;
  assign out_grade_mask_o = mask_q;
  assign out_max_mag_o    = max_q;

`ifdef GA_GRADE_SCAN_PERF_EN
  logic [31:0] perf_ops_q, perf_busy_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_ops_q  <= '0;
      perf_busy_q <= '0;
    end else begin
      if (out_vld_q && out_ready_i) perf_ops_q <= perf_ops_q + 32'd1;
      if (state_q != IDLE)          perf_busy_q <= perf_busy_q + 32'd1;
    end
  end

  assign perf_ops_o  = perf_ops_q;
  assign perf_busy_o = perf_busy_q;
`endif
endmodule

// File: tb/tb_ga_grade_scan.sv
// Randomized + directed bench for ga_grade_scan against a grade-table reference model.
module tb_ga_grade_scan;
  localparam int DIM = 5;
  localparam int NC  = 32;
  localparam int CW  = 16;
  localparam int MVW = NC*CW;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [MVW-1:0] in_mv = '0;
  logic [DIM:0]   in_keep = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [MVW-1:0] out_mv;
  logic [2:0]     out_grade;
  logic [DIM:0]   out_mask;
  logic [CW-1:0]  out_max;
`ifdef GA_GRADE_SCAN_PERF_EN
  logic [31:0]    perf_ops, perf_busy;
`endif

  always #5 clk = ~clk;

  ga_grade_scan dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .in_valid_i      (in_valid),
    .in_ready_o      (in_ready),
    .in_mv_i         (in_mv),
    .in_keep_i       (in_keep),
    .out_valid_o     (out_valid),
    .out_ready_i     (out_ready),
    .out_mv_o        (out_mv),
    .out_grade_o     (out_grade),
    .out_grade_mask_o(out_mask),
    .out_max_mag_o   (out_max)
`ifdef GA_GRADE_SCAN_PERF_EN
    ,
    .perf_ops_o      (perf_ops),
    .perf_busy_o     (perf_busy)
`endif
  );

  int n_chk = 0;
  int n_pass = 0;
  int gr [NC];
  int lat;

  task automatic chk(input string tag, input logic [MVW-1:0] obs, input logic [MVW-1:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic logic [MVW-1:0] put(input logic [MVW-1:0] mv, input int k, input logic [CW-1:0] v);
    mv[(NC-k)*CW-1 -: CW] = v;
    return mv;
  endfunction

  function automatic logic [CW-1:0] get(input logic [MVW-1:0] mv, input int k);
    return mv[(NC-k)*CW-1 -: CW];
  endfunction

  task automatic model(input logic [MVW-1:0] mv, input logic [DIM:0] keep,
                       output logic [2:0] g, output logic [DIM:0] m,
                       output logic [CW-1:0] mx, output logic [MVW-1:0] p);
    int gm [DIM+1];
    int v;
    int best;
    for (int j = 0; j <= DIM; j++) gm[j] = 0;
    m = '0;
    p = '0;
    for (int k = 0; k < NC; k++) begin
      v = int'($signed(get(mv, k)));
      if (v < 0) v = -v;
      if (v != 0) m[gr[k]] = 1'b1;
      if (v > gm[gr[k]]) gm[gr[k]] = v;
      if (keep[gr[k]]) p = put(p, k, get(mv, k));
    end
    g = 3'd0;
    best = gm[0];
    for (int j = 1; j <= DIM; j++)
      if (gm[j] > best) begin best = gm[j]; g = 3'(j); end
    mx = CW'(best);
  endtask

  function automatic logic [MVW-1:0] rand_mv();
    logic [MVW-1:0] m;
    logic [CW-1:0]  v;
    int dens;
    m = '0;
    dens = $urandom_range(1, 4);
    for (int k = 0; k < NC; k++) begin
      case ($urandom_range(0, 3))
        0:       v = CW'($urandom_range(0, 63)) - 16'd32;
        1:       v = CW'($urandom);
        2:       v = $urandom_range(0, 1) ? 16'h8000 : 16'h7FFF;
        default: v = CW'($urandom_range(1, 9));
      endcase
      if ($urandom_range(0, 4) >= dens) v = '0;
      m = put(m, k, v);
    end
    return m;
  endfunction

  task automatic launch(input string tag, input logic [MVW-1:0] mv, input logic [DIM:0] keep);
    int w;
    w = 0;
    while (!in_ready && w < 20) begin step(); w++; end
    chk({tag, ".rdy"}, in_ready, 1);
    in_valid = 1'b1; in_mv = mv; in_keep = keep;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    lat = 1;
    while (!out_valid && lat < 40) begin step(); lat++; end
    chk({tag, ".lat"}, lat, 9);
  endtask

  task automatic check_out(input string tag, input logic [2:0] eg, input logic [DIM:0] em,
                           input logic [CW-1:0] emx, input logic [MVW-1:0] ep);
    chk({tag, ".grade"}, out_grade, eg);
    chk({tag, ".mask"},  out_mask,  em);
    chk({tag, ".max"},   out_max,   emx);
    chk({tag, ".mv"},    out_mv,    ep);
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, ".vld_drop"}, out_valid, 0);
    chk({tag, ".rdy_back"}, in_ready, 1);
  endtask

  task automatic run(input string tag, input logic [MVW-1:0] mv, input logic [DIM:0] keep,
                     input logic [2:0] eg, input logic [DIM:0] em, input logic [CW-1:0] emx,
                     input logic [MVW-1:0] ep);
    launch(tag, mv, keep);
    wait_done(tag);
    check_out(tag, eg, em, emx, ep);
    release_out(tag);
  endtask

  task automatic run_model(input string tag, input logic [MVW-1:0] mv, input logic [DIM:0] keep);
    logic [2:0] g; logic [DIM:0] m; logic [CW-1:0] mx; logic [MVW-1:0] p;
    model(mv, keep, g, m, mx, p);
    run(tag, mv, keep, g, m, mx, p);
  endtask

  initial begin
    int cnt [DIM+1] = '{1, 5, 10, 10, 5, 1};
    int idx;
    logic [MVW-1:0] mv, mvb, pa, pb;
    logic [2:0] ga, gb; logic [DIM:0] ma, mb; logic [CW-1:0] xa, xb;

    idx = 0;
    for (int g = 0; g <= DIM; g++)
      for (int n = 0; n < cnt[g]; n++) begin gr[idx] = g; idx++; end

    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk("rst.rdy", in_ready, 1);
    chk("rst.vld", out_valid, 0);
    check_out("rst", 3'd0, 6'd0, 16'd0, '0);
`ifdef GA_GRADE_SCAN_PERF_EN
    chk("rst.perf_ops", perf_ops, 0);
    chk("rst.perf_busy", perf_busy, 0);
`endif

    mv = put('0, 0, 16'h0005);
    run("scalar", mv, 6'h3F, 3'd0, 6'b000001, 16'h0005, mv);
    mv = put(put(put('0, 0, 16'h000A), 2, 16'hFFF0), 6, 16'h000F);
    run("vec_biv", mv, 6'h3F, 3'd1, 6'b000111, 16'h0010, mv);
    mv = put(put('0, 1, 16'h0020), 16, 16'hFFE0);
    run("tie_proj", mv, 6'b001000, 3'd1, 6'b001010, 16'h0020, put('0, 16, 16'hFFE0));
    mv = put('0, 31, 16'h8000);
    run("pseudo_min", mv, 6'h3F, 3'd5, 6'b100000, 16'h8000, mv);
    run("zero", '0, 6'h3F, 3'd0, 6'd0, 16'd0, '0);
    run_model("keep_none", rand_mv(), 6'd0);

    for (int i = 0; i < 24; i++) run_model($sformatf("rnd%0d", i), rand_mv(), 6'($urandom));

    // Backpressure: hold result, offer a second request that must wait.
    mv  = rand_mv();
    mvb = rand_mv();
    model(mv, 6'h3F, ga, ma, xa, pa);
    model(mvb, 6'h15, gb, mb, xb, pb);
    launch("bp_a", mv, 6'h3F);
    wait_done("bp_a");
    in_valid = 1'b1; in_mv = mvb; in_keep = 6'h15;
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("bp.hold%0d.vld", c), out_valid, 1);
      chk($sformatf("bp.hold%0d.rdy", c), in_ready, 0);
      check_out($sformatf("bp.hold%0d", c), ga, ma, xa, pa);
    end
    release_out("bp_a");
    step();
    chk("bp_b.accepted", in_ready, 0);
    in_valid = 1'b0;
    wait_done("bp_b");
    check_out("bp_b", gb, mb, xb, pb);
    release_out("bp_b");

    // Leave a nonzero result in the output registers, then reset mid-scan.
    mv = put('0, 20, 16'h1234);
    run_model("pre_rst", mv, 6'h3F);
    launch("mid_rst", rand_mv(), 6'h3F);
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst.vld", out_valid, 0);
    chk("mid_rst.rdy", in_ready, 1);
    check_out("mid_rst", 3'd0, 6'd0, 16'd0, '0);
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      step();
      chk($sformatf("post_rst%0d.vld", c), out_valid, 0);
    end
    chk("post_rst.rdy", in_ready, 1);
    run_model("post_rst_op", rand_mv(), 6'h3F);
`ifdef GA_GRADE_SCAN_PERF_EN
    chk("perf.busy", perf_busy, 9);
    chk("perf.ops", perf_ops, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
